// File: rtl/booth_mult_arbiter_if.sv
// Client and datapath bus of the Booth multiplier arbiter.
// The slave modport is the arbiter side; the master modport drives requests and the datapath returns.
interface booth_mult_arbiter_if #(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*SIZE-1:0] op_a;
    logic [NUM_REQ*SIZE-1:0] op_b;
    logic [NUM_REQ-1:0]      ack;
    logic [2*SIZE-1:0]       result;
    logic                    err;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    busy;
    logic                    dp_start;
    logic [SIZE-1:0]         dp_a;
    logic [SIZE-1:0]         dp_b;
    logic                    dp_done;
    logic [2*SIZE-1:0]       dp_product;

    modport slave (
        input  req, op_a, op_b, dp_done, dp_product,
        output ack, result, err, gnt_idx, busy, dp_start, dp_a, dp_b
    );

    modport master (
        output req, op_a, op_b, dp_done, dp_product,
        input  ack, result, err, gnt_idx, busy, dp_start, dp_a, dp_b
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier datapath among NUM_REQ requesters.
// Define BOOTH_ARB_TIMEOUT_EN to add a watchdog that ends a stalled operation with err=1.
module booth_mult_arbiter #(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input logic                 clk,
    input logic                 rst,
    booth_mult_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]   gnt_n, pick_idx;
    logic               pick_vld;
    logic [NUM_REQ-1:0] ack_n;
    logic [2*SIZE-1:0]  result_n;
    logic               busy_n, start_n;
    logic [SIZE-1:0]    dp_a_n, dp_b_n;
    int                 scan;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(SIZE + 5);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;
    logic            err_n;

    // wd_cnt is 0 in the first BUSY cycle, so this is the (SIZE+4)th BUSY cycle
    assign wd_hit = (wd_cnt == WD_W'(SIZE + 3));
`endif

    // First requesting index after the last served one, wrapping around
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = (int'(rr_ptr) + k) % NUM_REQ;
            if (!pick_vld && bus.req[scan]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(scan);
            end
        end
    end

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        gnt_n    = bus.gnt_idx;
        ack_n    = '0;
        result_n = bus.result;
        busy_n   = bus.busy;
        start_n  = bus.dp_start;
        dp_a_n   = bus.dp_a;
        dp_b_n   = bus.dp_b;
`ifdef BOOTH_ARB_TIMEOUT_EN
        err_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_n   = pick_idx;
                    dp_a_n  = bus.op_a[pick_idx*SIZE +: SIZE];
                    dp_b_n  = bus.op_b[pick_idx*SIZE +: SIZE];
                    start_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                // req is deliberately not looked at here: a started operation always completes
                if (bus.dp_done) begin
                    result_n             = bus.dp_product;
                    ack_n[bus.gnt_idx]   = 1'b1;
                    start_n              = 1'b0;
                    rr_ptr_n             = bus.gnt_idx;
                    state_n              = RESP;
                end
`ifdef BOOTH_ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    result_n             = '0;
                    err_n                = 1'b1;
                    ack_n[bus.gnt_idx]   = 1'b1;
                    start_n              = 1'b0;
                    rr_ptr_n             = bus.gnt_idx;
                    state_n              = RESP;
                end
`endif
            end
            RESP: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            bus.ack      <= '0;
            bus.result   <= '0;
            bus.gnt_idx  <= '0;
            bus.busy     <= 1'b0;
            bus.dp_start <= 1'b0;
            bus.dp_a     <= '0;
            bus.dp_b     <= '0;
        end else begin
            state        <= state_n;
            rr_ptr       <= rr_ptr_n;
            bus.ack      <= ack_n;
            bus.result   <= result_n;
            bus.gnt_idx  <= gnt_n;
            bus.busy     <= busy_n;
            bus.dp_start <= start_n;
            bus.dp_a     <= dp_a_n;
            bus.dp_b     <= dp_b_n;
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            bus.err <= 1'b0;
        end else begin
            wd_cnt  <= (state == BUSY) ? wd_cnt + WD_W'(1) : '0;
            bus.err <= err_n;
        end
    end
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one Booth multiplier datapath (controller plus datapath, one operation at a time) between NUM_REQ independent requesters.
- Grants round-robin, latches the winner's operands, and holds the datapath start level for the whole operation.
- Captures the product on dp_done and returns it to the granted requester with a one-cycle ack.
- Sits between client blocks and the existing Booth controller/datapath pair.

Parameters:
- SIZE, 8, operand width in bits; product is 2*SIZE.
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the grant index; must be at least ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- op_a  in  NUM_REQ*SIZE  multiplicands, requester i at bits [i*SIZE +: SIZE].
- op_b  in  NUM_REQ*SIZE  multipliers, same packing as op_a.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- result  out  2*SIZE  product, valid only while any ack bit is high.
- err  out  1  timeout flag, valid with ack; constant 0 when the optional feature is off.
- gnt_idx  out  IDX_W  index of the current or last granted requester.
- busy  out  1  high in BUSY and RESP.
- dp_start  out  1  start level to the Booth controller.
- dp_a  out  SIZE  multiplicand to the datapath.
- dp_b  out  SIZE  multiplier to the datapath.
- dp_done  in  1  one-cycle pulse from the datapath: product valid.
- dp_product  in  2*SIZE  datapath product, sampled when dp_done is high.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; ack=0; result=0; err=0; gnt_idx=0; busy=0; dp_start=0; dp_a=0; dp_b=0; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation drops dp_start the next cycle and issues no ack. The datapath sees start low, and its own controller disables it.
- State IDLE: if any req bit is high, pick the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Latch that requester's op_a/op_b into dp_a/dp_b and set gnt_idx to its index.
  - Set dp_start=1 and busy=1, then go to BUSY.
  - If no req bit is high, stay in IDLE.
- State BUSY: dp_start held at 1 and dp_a/dp_b held stable.
  - req changes, including withdrawal by the granted requester, are ignored; the operation always completes.
  - On dp_done=1: result<=dp_product, ack[gnt_idx]<=1, dp_start<=0, rr_ptr<=gnt_idx, then go to RESP.
- State RESP: lasts exactly one cycle with ack and result valid.
  - Next cycle: ack<=0, busy<=0, result holds its value, go to IDLE.
- Requester rule: req stays high until ack is sampled high, and is cleared at that same edge. The arbiter therefore never re-grants a completed request.
- Latency: grant at edge E0; dp_start high from E0. dp_done arriving in cycle k gives ack in cycle k+1. With the Booth controller (done SIZE+1 cycles after start), req-to-ack is SIZE+3 cycles.
- dp_done seen while in IDLE or RESP is ignored.
- Simultaneous requests are served in rotation; the maximum wait for any requester is NUM_REQ-1 operations.
- Operands are unsigned-agnostic. The arbiter never interprets or modifies data; widths pass through unchanged.

Optional Feature:
- Macro: BOOTH_ARB_TIMEOUT_EN.
- When defined: a watchdog counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches SIZE+4 without dp_done: result<=0, err<=1, ack[gnt_idx]<=1, dp_start<=0, rr_ptr<=gnt_idx, go to RESP.
  - err is cleared with ack.
  - dp_done in the same cycle the counter hits the limit wins: normal completion, err=0.
- When undefined: no watchdog, err tied to 0, and BUSY waits indefinitely for dp_done.

Test Plan:
1. Reset then single request: req=4'b0001, op_a[7:0]=13, op_b[7:0]=11, datapath model done 9 cycles after start -> dp_a=13, dp_b=11, dp_start=1 on the grant cycle; ack=4'b0001 with result=143, err=0, exactly 11 cycles after req is sampled.
2. All four requesting, operands i+2 and i+3 for requester i -> grants in order 0,1,2,3; results 6,12,20,30; exactly one ack bit per completion; no idle gap beyond the RESP cycle.
3. Fairness: after requester 2 completes, req=4'b0101 -> requester 0 granted next, then 2.
4. Withdrawal and stray done: requester 1 drops req mid-BUSY -> operation completes, ack[1] still pulses. A dp_done pulse injected in IDLE -> no ack, state unchanged.
5. Synchronous rst asserted 4 cycles into BUSY -> next cycle dp_start=0, busy=0, ack=0, gnt_idx=0; afterwards req=4'b1001 grants requester 0 first.
6. With BOOTH_ARB_TIMEOUT_EN: datapath never asserts dp_done -> ack at BUSY cycle 12 with err=1, result=0. Also dp_done exactly at the limit -> err=0 and the correct product.
